// File: rtl/jtbubl_sndcomm.sv
// Main-to-sound command channel, sound CPU side: command latch, reply byte,
// status window and NMI generation, all in the clk24 domain.
module jtbubl_sndcomm #(
  parameter bit RST_KEEPS_CMD = 1'b1
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       snd_rst,
  input  logic       main_cmd_we,
  input  logic [7:0] main_din,
  input  logic       main_reply_rd,
  output logic [7:0] main_reply,
  output logic       reply_pend,
  input  logic       snd_cs,
  input  logic [1:0] snd_addr,
  input  logic       snd_rdn,
  input  logic       snd_wrn,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_nmi_n,
  output logic       cmd_ovf
);

  logic [7:0] cmd_latch;
  logic       cmd_pend;
  logic       nmi_en;
  logic       rd_l, wr_l, mwr_l, mrd_l;
  logic       rd_lvl, wr_lvl;
  logic       rd_ev, wr_ev, main_wr_ev, main_rd_ev;
  logic       rd_cmd;
  logic [7:0] dout_nx;

  assign rd_lvl     = snd_cs & ~snd_rdn;
  assign wr_lvl     = snd_cs & ~snd_wrn;
  // Sound-side strobes are ignored while the sound CPU is held in reset
  assign rd_ev      = rd_lvl & ~rd_l & ~snd_rst;
  assign wr_ev      = wr_lvl & ~wr_l & ~snd_rst;
  assign main_wr_ev = main_cmd_we & ~mwr_l;
  assign main_rd_ev = main_reply_rd & ~mrd_l;
  assign rd_cmd     = rd_ev && (snd_addr == 2'd0);

  always_comb begin
    dout_nx = 8'hFF;
    case (snd_addr)
      2'd0:    dout_nx = cmd_latch;
      2'd1:    dout_nx = {6'd0, reply_pend, cmd_pend};
      default: dout_nx = 8'hFF;
    endcase
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      main_reply <= 8'd0;
      reply_pend <= 1'b0;
      snd_dout   <= 8'hFF;
      snd_nmi_n  <= 1'b1;
      cmd_ovf    <= 1'b0;
      cmd_latch  <= 8'd0;
      cmd_pend   <= 1'b0;
      nmi_en     <= 1'b0;
      rd_l       <= 1'b1;
      wr_l       <= 1'b1;
      mwr_l      <= 1'b1;
      mrd_l      <= 1'b1;
    end else begin
      mwr_l     <= main_cmd_we;
      mrd_l     <= main_reply_rd;
      rd_l      <= snd_rst | rd_lvl;
      wr_l      <= snd_rst | wr_lvl;
      snd_dout  <= dout_nx;
      snd_nmi_n <= ~(cmd_pend & nmi_en);

      // Clears first, sets last, so a coincident set always wins
      if (rd_cmd) cmd_pend <= 1'b0;
      if (wr_ev && snd_addr == 2'd3) cmd_ovf <= 1'b0;
      if (snd_rst && !RST_KEEPS_CMD) begin
        cmd_latch <= 8'd0;
        cmd_pend  <= 1'b0;
        cmd_ovf   <= 1'b0;
      end
      if (main_wr_ev) begin
        cmd_latch <= main_din;
        cmd_pend  <= 1'b1;
        if (cmd_pend && !rd_cmd) cmd_ovf <= 1'b1;
      end

      if (main_rd_ev) reply_pend <= 1'b0;
      if (wr_ev) begin
        case (snd_addr)
          2'd0: begin
            main_reply <= snd_din;
            reply_pend <= 1'b1;
          end
          2'd1:    nmi_en <= 1'b1;
          2'd2:    nmi_en <= 1'b0;
          default: ;
        endcase
      end
      if (snd_rst) begin
        nmi_en     <= 1'b0;
        reply_pend <= 1'b0;
        main_reply <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Directed bench for jtbubl_sndcomm; two instances differ only in RST_KEEPS_CMD.
module tb_jtbubl_sndcomm;

  logic       clk24 = 1'b0;
  logic       rst, snd_rst, main_cmd_we, main_reply_rd;
  logic [7:0] main_din, snd_din;
  logic       snd_cs, snd_rdn, snd_wrn;
  logic [1:0] snd_addr;

  logic [7:0] a_reply, a_dout, b_reply, b_dout;
  logic       a_rpend, a_nmi, a_ovf, b_rpend, b_nmi, b_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk24 = ~clk24;

  jtbubl_sndcomm #(.RST_KEEPS_CMD(1'b1)) u_keep (
    .clk24(clk24), .rst(rst), .snd_rst(snd_rst),
    .main_cmd_we(main_cmd_we), .main_din(main_din), .main_reply_rd(main_reply_rd),
    .main_reply(a_reply), .reply_pend(a_rpend),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_rdn(snd_rdn), .snd_wrn(snd_wrn),
    .snd_din(snd_din), .snd_dout(a_dout), .snd_nmi_n(a_nmi), .cmd_ovf(a_ovf)
  );

  jtbubl_sndcomm #(.RST_KEEPS_CMD(1'b0)) u_clr (
    .clk24(clk24), .rst(rst), .snd_rst(snd_rst),
    .main_cmd_we(main_cmd_we), .main_din(main_din), .main_reply_rd(main_reply_rd),
    .main_reply(b_reply), .reply_pend(b_rpend),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_rdn(snd_rdn), .snd_wrn(snd_wrn),
    .snd_din(snd_din), .snd_dout(b_dout), .snd_nmi_n(b_nmi), .cmd_ovf(b_ovf)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic main_write(input logic [7:0] d);
    main_din    = d;
    main_cmd_we = 1'b1;
    repeat (4) tick();
    main_cmd_we = 1'b0;
    tick();
  endtask

  task automatic snd_write(input logic [1:0] a, input logic [7:0] d);
    snd_addr = a;
    snd_din  = d;
    snd_cs   = 1'b1;
    snd_wrn  = 1'b0;
    repeat (2) tick();
    snd_cs   = 1'b0;
    snd_wrn  = 1'b1;
    snd_addr = 2'd1;
    tick();
  endtask

  initial begin
    rst = 1'b1; snd_rst = 1'b0; main_cmd_we = 1'b0; main_reply_rd = 1'b0;
    main_din = 8'd0; snd_din = 8'd0; snd_cs = 1'b0; snd_rdn = 1'b1; snd_wrn = 1'b1;
    snd_addr = 2'd1;
    repeat (3) tick();
    check("rst_reply",  a_reply, 8'h00);
    check("rst_rpend",  {7'd0, a_rpend}, 8'h00);
    check("rst_dout",   a_dout, 8'hFF);
    check("rst_nmi",    {7'd0, a_nmi}, 8'h01);
    check("rst_ovf",    {7'd0, a_ovf}, 8'h00);
    rst = 1'b0;
    tick();
    check("idle_status", a_dout, 8'h00);

    // command with NMI disabled, then enable NMI
    main_din = 8'h5A; main_cmd_we = 1'b1;
    tick();
    check("we_nmi_t1", {7'd0, a_nmi}, 8'h01);
    tick();
    check("pend_status", a_dout, 8'h01);
    check("we_nmi_t2", {7'd0, a_nmi}, 8'h01);
    repeat (2) tick();
    main_cmd_we = 1'b0;
    tick();
    check("status_5a", a_dout, 8'h01);
    snd_addr = 2'd1; snd_cs = 1'b1; snd_wrn = 1'b0;
    tick();
    check("nmien_t1", {7'd0, a_nmi}, 8'h01);
    tick();
    check("nmien_t2", {7'd0, a_nmi}, 8'h00);
    snd_cs = 1'b0; snd_wrn = 1'b1;
    tick();

    // read command byte; pending and NMI release
    snd_addr = 2'd0; snd_cs = 1'b1; snd_rdn = 1'b0;
    tick();
    check("rd_latch", a_dout, 8'h5A);
    check("rd_nmi_t1", {7'd0, a_nmi}, 8'h00);
    tick();
    check("rd_nmi_t2", {7'd0, a_nmi}, 8'h01);
    tick();
    snd_cs = 1'b0; snd_rdn = 1'b1; snd_addr = 2'd1;
    tick();
    check("status_clr", a_dout, 8'h00);
    snd_addr = 2'd2;
    tick();
    check("addr2_ff", a_dout, 8'hFF);
    snd_addr = 2'd3;
    tick();
    check("addr3_ff", a_dout, 8'hFF);
    snd_addr = 2'd1;

    // overflow
    main_write(8'h11);
    check("ovf_first", {7'd0, a_ovf}, 8'h00);
    main_write(8'h22);
    check("ovf_set", {7'd0, a_ovf}, 8'h01);
    snd_addr = 2'd0; snd_cs = 1'b1; snd_rdn = 1'b0;
    tick();
    check("ovf_latch", a_dout, 8'h22);
    snd_cs = 1'b0; snd_rdn = 1'b1; snd_addr = 2'd1;
    tick();
    snd_write(2'd3, 8'h00);
    check("ovf_clr", {7'd0, a_ovf}, 8'h00);

    // reply path
    snd_write(2'd0, 8'hC3);
    check("reply_byte", a_reply, 8'hC3);
    check("reply_pend", {7'd0, a_rpend}, 8'h01);
    snd_addr = 2'd0; snd_din = 8'h3C; snd_cs = 1'b1; snd_wrn = 1'b0; main_reply_rd = 1'b1;
    tick();
    check("reply_race_pend", {7'd0, a_rpend}, 8'h01);
    check("reply_race_byte", a_reply, 8'h3C);
    snd_cs = 1'b0; snd_wrn = 1'b1; main_reply_rd = 1'b0; snd_addr = 2'd1;
    tick();
    main_reply_rd = 1'b1;
    tick();
    check("reply_rd_pend", {7'd0, a_rpend}, 8'h00);
    check("reply_rd_byte", a_reply, 8'h3C);
    main_reply_rd = 1'b0;
    tick();

    // sound reset with command pending and NMI enabled
    snd_write(2'd0, 8'hAB);
    main_write(8'h99);
    check("pre_srst_nmi", {7'd0, a_nmi}, 8'h00);
    snd_addr = 2'd0; snd_cs = 1'b1; snd_rdn = 1'b0; snd_rst = 1'b1;
    repeat (3) tick();
    check("srst_reply", a_reply, 8'h00);
    check("srst_rpend", {7'd0, a_rpend}, 8'h00);
    check("srst_nmi", {7'd0, a_nmi}, 8'h01);
    snd_rst = 1'b0;
    repeat (3) tick();
    snd_cs = 1'b0; snd_rdn = 1'b1; snd_addr = 2'd1;
    repeat (2) tick();
    check("srst_keep_status", a_dout, 8'h01);
    check("srst_clr_status", b_dout, 8'h00);
    check("srst_keep_nmi", {7'd0, a_nmi}, 8'h01);
    check("srst_clr_nmi", {7'd0, b_nmi}, 8'h01);

    // main write coincident with a sound read edge at addr 0
    main_din = 8'h77; main_cmd_we = 1'b1;
    snd_addr = 2'd0; snd_cs = 1'b1; snd_rdn = 1'b0;
    tick();
    snd_cs = 1'b0; snd_rdn = 1'b1; snd_addr = 2'd1;
    repeat (3) tick();
    main_cmd_we = 1'b0;
    tick();
    check("race_keep_status", a_dout, 8'h01);
    check("race_clr_status", b_dout, 8'h01);
    check("race_keep_ovf", {7'd0, a_ovf}, 8'h00);
    check("race_clr_ovf", {7'd0, b_ovf}, 8'h00);
    snd_addr = 2'd0;
    tick();
    check("race_latch", a_dout, 8'h77);
    check("race_latch_b", b_dout, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtbubl_sndcomm.md
# jtbubl_sndcomm

Sound-CPU side of the main-to-sound command channel: it receives command bytes written by the main CPU into the sound latch and presents them to the sound CPU through a small register window. It raises the sound CPU NMI when a command is pending and NMI is enabled, and returns a reply byte plus a pending flag to the main CPU. It sits between the main CPU bus decode and the sound CPU address decoder. Everything runs in the 24 MHz domain.

## Interface
Parameters:
- RST_KEEPS_CMD, 1, when 1 `snd_rst` preserves `cmd_latch`/`cmd_pend`; when 0 it clears them too

Ports:
- clk24  in  1  system clock; only clock in the block
- rst  in  1  reset, synchronous, active-high
- snd_rst  in  1  sound CPU reset (active high), from main-side control register
- main_cmd_we  in  1  main CPU write strobe to command latch, level, held several clk24 cycles
- main_din  in  8  main CPU data bus
- main_reply_rd  in  1  main CPU read strobe of reply, level
- main_reply  out  8  reply byte for main CPU
- reply_pend  out  1  reply byte not yet read by main CPU
- snd_cs  in  1  sound CPU comm window select (mreq decoded)
- snd_addr  in  2  sound CPU address bits [1:0]
- snd_rdn  in  1  sound CPU read, active low
- snd_wrn  in  1  sound CPU write, active low
- snd_din  in  8  sound CPU data out
- snd_dout  out  8  data to sound CPU input mux, registered
- snd_nmi_n  out  1  NMI to sound CPU, active low
- cmd_ovf  out  1  sticky: main wrote while previous command still pending

## Operation
- Strobe events: rd_ev = snd_cs & !snd_rdn rising; wr_ev = snd_cs & !snd_wrn rising; main_wr_ev = main_cmd_we rising; main_rd_ev = main_reply_rd rising. Rising = high now, low previous clk24 cycle; each access acts exactly once.
- main_wr_ev: cmd_latch <= main_din, cmd_pend <= 1; if cmd_pend already 1, cmd_ovf <= 1.
- Sound window, reads (snd_dout):
  - addr 0: cmd_latch. rd_ev clears cmd_pend.
  - addr 1: {6'b0, reply_pend, cmd_pend}. No side effect.
  - addr 2, 3: 8'hFF.
- Sound window, writes:
  - addr 0: main_reply <= snd_din, reply_pend <= 1.
  - addr 1: nmi_en <= 1.
  - addr 2: nmi_en <= 0.
  - addr 3: cmd_ovf <= 0.
- main_rd_ev clears reply_pend. main_reply is unchanged by reads.
- NMI: snd_nmi_n <= ~(cmd_pend & nmi_en). It is a level output; the Z80 edge-detects it. Reading addr 0 releases it.
- Simultaneous events, set wins:
  - main_wr_ev with rd_ev: cmd_pend stays 1, latch takes the new byte, cmd_ovf not set.
  - Sound write addr 0 with main_rd_ev: reply_pend stays 1.
  - Sound write addr 3 with overflowing main_wr_ev: cmd_ovf ends 1.
- snd_rst high, held: nmi_en = 0, reply_pend = 0, main_reply = 0, sound-side edge detectors forced to "previous high" so no event fires on release. cmd_latch/cmd_pend/cmd_ovf kept if RST_KEEPS_CMD=1, else cleared. Main-side writes are still accepted during snd_rst.

## Timing
- Values after rst: main_reply = 0, reply_pend = 0, snd_dout = 8'hFF, snd_nmi_n = 1, cmd_ovf = 0, cmd_latch = 0, cmd_pend = 0, nmi_en = 0; edge-detector history = 1.
- Flag updates land on the clk24 edge after the first cycle a strobe is seen high.
  - cmd_pend: visible 1 cycle after main_cmd_we rises.
  - snd_nmi_n: falls 2 cycles after main_cmd_we rises (flag, then NMI register).
- snd_dout: registered every cycle from the current snd_addr. Valid 1 cycle after snd_cs & !snd_rdn; the read that clears cmd_pend still returns the latch value.
- reply_pend/main_reply: update 1 cycle after the sound write rises.
- rst overrides snd_rst; both are synchronous.

## Test plan
- After rst, main writes 8'h5A (cmd_we high 4 cycles) with nmi_en=0 -> cmd_pend=1 after 1 cycle, snd_nmi_n stays 1, status read = 8'h01. Sound writes addr 1 -> snd_nmi_n=0 two cycles later.
- Sound reads addr 0 (rdn low 3 cycles) -> snd_dout=8'h5A, cmd_pend=0 once, snd_nmi_n=1 one cycle after clear. Status read = 8'h00.
- Main writes 8'h11 then 8'h22 without a sound read -> cmd_ovf=1, latch=8'h22. Sound write addr 3 -> cmd_ovf=0.
- Sound writes 8'hC3 to addr 0 -> main_reply=8'hC3, reply_pend=1. A main read in the same cycle as a second sound write -> reply_pend stays 1. A later lone main read -> 0.
- snd_rst pulsed with cmd_pend=1, nmi_en=1, RST_KEEPS_CMD=1 -> nmi_en=0, reply_pend=0, cmd_pend=1, snd_nmi_n=1; no spurious event on release. Same with RST_KEEPS_CMD=0 -> cmd_pend=0.
- Main write 8'h77 in the same cycle as a sound read edge at addr 0 -> cmd_pend ends 1, latch 8'h77, cmd_ovf 0.
